// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_sub_if.sv
// Request/response bundle between a requester and serial_add_sub.
import serial_add_sub_pkg::*;

interface serial_add_sub_if #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             n;
  logic             z;
  logic             c;
  logic             v;

  modport master (output start, sub, a, b,
                  input  busy, done, result, n, z, c, v);
  modport slave  (input  start, sub, a, b,
                  output busy, done, result, n, z, c, v);
endinterface

// File: rtl/serial_add_sub_full_adder.sv
// One-bit full adder cell used by the serial datapath.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract, LSB first, one bit per RUN cycle, ARM-style NZCV flags.
import serial_add_sub_pkg::*;

module serial_add_sub #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  serial_add_sub_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [1:0]    S_IDLE = 2'(IDLE);
  localparam logic [1:0]    S_RUN  = 2'(RUN);
  localparam logic [1:0]    S_DONE = 2'(DONE);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL   = CW'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sub_q, sub_d, carry_q, carry_d, cmsb_q, cmsb_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
  logic             sum, cout;

  fullAdder u_full_adder (
    .a    (a_q[0]),
    .b    (b_q[0] ^ sub_q),
    .cin  (carry_q),
    .s    (sum),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      cmsb_q   <= cmsb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
    end
  end

  // WIDTH shift cycles, then one extra RUN cycle that latches the flags and raises done.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    cmsb_d   = cmsb_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    n_d      = n_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          carry_d = bus.sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (cnt_q == FULL) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          n_d     = result_q[WIDTH-1];
          z_d     = (result_q == '0);
          c_d     = carry_q;
          v_d     = cmsb_q ^ carry_q;
        end else begin
          a_d      = a_q >> 1;
          b_d      = b_q >> 1;
          carry_d  = cout;
          result_d = {sum, result_q[WIDTH-1:1]};
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cmsb_d = carry_q;
            busy_d = 1'b0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.n      = n_q;
  assign bus.z      = z_q;
  assign bus.c      = c_q;
  assign bus.v      = v_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed self-checking bench for serial_add_sub at WIDTH=64.
module tb_serial_add_sub;
  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  serial_add_sub_if #(.WIDTH(64)) bus ();

  serial_add_sub #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation and observe 80 cycles after the accepting edge.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic sub, input logic [63:0] exp_res, input logic [3:0] exp_nzcv,
                        input int pulse_at);
    int          busy_cnt;
    int          done_cnt;
    int          done_idx;
    logic [63:0] res_at_done;
    logic [3:0]  nzcv_at_done;
    busy_cnt     = 0;
    done_cnt     = 0;
    done_idx     = -1;
    res_at_done  = '0;
    nzcv_at_done = '0;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 80; i++) begin
      bus.start = 1'b0;
      if (i == pulse_at) begin
        bus.start = 1'b1;
        bus.a     = 64'h0;
        bus.b     = 64'h1234;
        bus.sub   = ~sub;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_idx     = i;
        res_at_done  = bus.result;
        nzcv_at_done = {bus.n, bus.z, bus.c, bus.v};
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd64);
    check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " done_index"},  64'(done_idx), 64'd65);
    check({tag, " result_at_done"}, res_at_done, exp_res);
    check({tag, " nzcv_at_done"}, 64'(nzcv_at_done), 64'(exp_nzcv));
    check({tag, " result_hold"}, bus.result, exp_res);
    check({tag, " nzcv_hold"}, 64'({bus.n, bus.z, bus.c, bus.v}), 64'(exp_nzcv));
  endtask

  initial begin
    int done_seen;
    clk       = 1'b0;
    reset     = 1'b1;
    n_assert  = 0;
    n_fail    = 0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset busy",   64'(bus.busy), 64'd0);
    check("reset done",   64'(bus.done), 64'd0);
    check("reset result", bus.result, 64'd0);
    check("reset nzcv",   64'({bus.n, bus.z, bus.c, bus.v}), 64'd0);
    @(posedge clk); #1;

    run_op("add_5_3",    64'd5, 64'd3, 1'b0, 64'd8, 4'b0000, -1);
    run_op("add_ovf",    64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001, -1);
    run_op("add_carry",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0110, -1);
    run_op("sub_3_3",    64'd3, 64'd3, 1'b1, 64'd0, 4'b0110, -1);
    run_op("sub_0_1",    64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, -1);

    // Abort mid-run: reset lands on the edge ending RUN cycle 20.
    bus.a     = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.b     = 64'd0;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("pre_abort busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort busy",   64'(bus.busy), 64'd0);
    check("abort done",   64'(bus.done), 64'd0);
    check("abort result", bus.result, 64'd0);
    check("abort nzcv",   64'({bus.n, bus.z, bus.c, bus.v}), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.done || bus.busy) done_seen++;
      @(posedge clk); #1;
    end
    check("abort no_done", 64'(done_seen), 64'd0);

    run_op("ignore_start", 64'd100, 64'd23, 1'b0, 64'd123, 4'b0000, 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
